imem_refill_responder: RTL and testbench

IMEM_REFILL_RESPONDER -- requirements
Module: imem_refill_responder

---
 rtl/imem_refill_responder_pkg.sv | 7 +
 rtl/imem_refill_responder_if.sv | 25 ++
 rtl/imem_refill_responder_imem_array.sv | 26 ++
 rtl/imem_refill_responder.sv | 131 +++++++++++++
 tb/tb_imem_refill_responder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_refill_responder_pkg.sv
// Shared memory-interface parameters used by the icache and by its refill responder.
package imem_refill_responder_pkg;
  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int CACHE_LINE_WORDS = 4;
  localparam int OFFSET_BITS      = $clog2(CACHE_LINE_WORDS);
endpackage

// File: rtl/imem_refill_responder_if.sv
// Refill bus between the icache refill engine (master) and the responder (slave).
interface imem_refill_responder_if #(
    parameter int ADDR_WIDTH = imem_refill_responder_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = imem_refill_responder_pkg::DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_valid;
    logic                  stall_inject;
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  busy;

    modport master (
        output mem_addr, mem_req, stall_inject, prog_we, prog_addr, prog_data,
        input  mem_data, mem_valid, busy
    );

    modport slave (
        input  mem_addr, mem_req, stall_inject, prog_we, prog_addr, prog_data,
        output mem_data, mem_valid, busy
    );
endinterface

// File: rtl/imem_refill_responder_imem_array.sv
// Backing store: one write port and one registered read port (read-before-write).
module imem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         re,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);
    logic [DATA_WIDTH-1:0] store [MEM_WORDS];

    // The store itself has no reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) store[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= store[raddr];
    end
endmodule

// File: rtl/imem_refill_responder.sv
// Instruction-memory refill responder: returns a cache line as wrapped beats after a fixed latency.
module imem_refill_responder #(
    parameter int ADDR_WIDTH       = imem_refill_responder_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH       = imem_refill_responder_pkg::DATA_WIDTH,
    parameter int CACHE_LINE_WORDS = imem_refill_responder_pkg::CACHE_LINE_WORDS,
    parameter int MEM_WORDS        = 4096,
    parameter int FIRST_LATENCY    = 4
) (
    input logic                    clk,
    input logic                    rst,
    imem_refill_responder_if.slave bus
);
    import imem_refill_responder_pkg::*;

    localparam int OFF_W  = $clog2(CACHE_LINE_WORDS);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - 2;
    localparam int LEFT_W = OFF_W + 1;
    localparam int LAT_W  = (FIRST_LATENCY > 2) ? $clog2(FIRST_LATENCY) : 1;

    localparam logic [LEFT_W-1:0] LINE_BEATS = LEFT_W'(CACHE_LINE_WORDS);
    localparam logic [LAT_W-1:0]  LAT_INIT   = LAT_W'((FIRST_LATENCY > 2) ? FIRST_LATENCY - 3 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t              state, state_n;
    logic [TAG_W-1:0]    base, base_n;
    logic [OFF_W-1:0]    beat, beat_n;
    logic [LEFT_W-1:0]   left, left_n;
    logic [LAT_W-1:0]    lat, lat_n;
    logic                valid_q;
    logic                issue;
    logic                abort;
    logic [TAG_W-1:0]    req_line, rd_line;
    logic [OFF_W-1:0]    req_beat, rd_beat;
    logic                unused_addr_bits;

    assign req_line         = bus.mem_addr[ADDR_WIDTH-1:OFF_W+2];
    assign req_beat         = bus.mem_addr[OFF_W+1:2];
    assign unused_addr_bits = ^bus.mem_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            beat    <= '0;
            left    <= '0;
            lat     <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            base    <= base_n;
            beat    <= beat_n;
            left    <= left_n;
            lat     <= lat_n;
            valid_q <= issue;
        end
    end

    // WAIT lasts FIRST_LATENCY-2 cycles so the registered beat lands exactly
    // FIRST_LATENCY cycles after acceptance; a latency of 1 issues from IDLE.
    always_comb begin
        state_n = state;
        base_n  = base;
        beat_n  = beat;
        left_n  = left;
        lat_n   = lat;
        issue   = 1'b0;
        rd_line = base;
        rd_beat = beat;
        abort   = !bus.mem_req || (req_line != base);
        unique case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    base_n = req_line;
                    beat_n = req_beat;
                    left_n = LINE_BEATS;
                    lat_n  = '0;
                    if (FIRST_LATENCY == 1) begin
                        state_n = BURST;
                        rd_line = req_line;
                        rd_beat = req_beat;
                        if (!bus.stall_inject) begin
                            issue  = 1'b1;
                            beat_n = req_beat + OFF_W'(1);
                            left_n = LINE_BEATS - LEFT_W'(1);
                        end
                    end else if (FIRST_LATENCY == 2) begin
                        state_n = BURST;
                    end else begin
                        state_n = WAIT;
                        lat_n   = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (abort)            state_n = IDLE;
                else if (lat == '0)   state_n = BURST;
                else                  lat_n   = lat - LAT_W'(1);
            end
            BURST: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (!bus.stall_inject) begin
                    issue  = 1'b1;
                    beat_n = beat + OFF_W'(1);
                    left_n = left - LEFT_W'(1);
                    if (left == LEFT_W'(1)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.prog_we && !rst),
        .waddr (IDX_W'(bus.prog_addr >> 2)),
        .wdata (bus.prog_data),
        .re    (issue),
        .raddr (IDX_W'({rd_line, rd_beat})),
        .rdata (bus.mem_data)
    );

    assign bus.mem_valid = valid_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_imem_refill_responder.sv
// Scoreboarded bench for imem_refill_responder with a line/beat-level reference model.
module tb_imem_refill_responder;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CLW = 4;
    localparam int MW  = 4096;
    localparam int FL  = 4;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_refill_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_refill_responder #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .CACHE_LINE_WORDS (CLW),
        .MEM_WORDS        (MW),
        .FIRST_LATENCY    (FL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t       exp_q[$];
    beat_t       b;
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_exp = '0;
    logic [31:0] mem_m [MW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every beat must match the head of the scoreboard in data and cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                total++;
                $display("FAIL beat_missing: no beat in cycle %0d, expected data 0x%0h", exp_q[0].cyc, exp_q[0].data);
                last_exp = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            if (bus.mem_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL beat_unexpected: mem_valid=1 data 0x%0h in cycle %0d, expected no beat", bus.mem_data, cyc);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", bus.mem_data, b.data);
                    check("beat_cycle", cyc, b.cyc);
                    last_exp = b.data;
                end
            end else begin
                check("hold_data", bus.mem_data, last_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.mem_req      = 1'b0;
        bus.stall_inject = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic prog(input logic [31:0] addr, input logic [31:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        step();
        bus.prog_we = 1'b0;
        mem_m[(addr >> 2) % MW] = data;
    endtask

    // Model: beat n of the line may appear in cycle t+k (k >= FL) only if
    // stall was low in cycle t+k-1; an abort in cycle a allows beats up to a.
    task automatic run_req(input logic [31:0] addr, input int abort_at, input bit abort_by_addr,
                           input logic [63:0] stall_mask, input int wr_k,
                           input logic [31:0] wr_addr, input logic [31:0] wr_data);
        int          idx, base, bt, n, lastk, endk, t;
        bit          aborted;
        int          ks[$];
        logic [31:0] ds[$];
        idx   = int'((addr >> 2) % MW);
        base  = idx & ~(CLW - 1);
        bt    = idx % CLW;
        n     = 0;
        lastk = 0;
        for (int k = FL; n < CLW; k++) begin
            if (stall_mask[k-1] !== 1'b1) begin
                ks.push_back(k);
                ds.push_back(mem_m[base + (bt + n) % CLW]);
                n++;
                lastk = k;
            end
        end
        aborted = (abort_at >= 0) && (abort_at < lastk);
        endk    = aborted ? abort_at : lastk;
        t       = cyc;
        foreach (ks[i])
            if (!aborted || ks[i] <= abort_at) exp_q.push_back(beat_t'{ds[i], t + ks[i]});
        for (int k = 0; k <= endk; k++) begin
            bus.mem_addr     = addr;
            bus.mem_req      = (k < lastk);
            bus.stall_inject = stall_mask[k];
            if (aborted && k == abort_at) begin
                if (abort_by_addr) bus.mem_addr = 32'h200;
                else               bus.mem_req  = 1'b0;
            end
            bus.prog_we   = (k == wr_k);
            bus.prog_addr = wr_addr;
            bus.prog_data = wr_data;
            step();
            if (k == wr_k) mem_m[(wr_addr >> 2) % MW] = wr_data;
        end
        bus.prog_we      = 1'b0;
        bus.stall_inject = 1'b0;
        if (!(aborted && abort_by_addr)) begin
            bus.mem_req = 1'b0;
            check("busy_after", bus.busy, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] mask;
        logic [31:0] addr;
        int          ab;
        rst              = 1'b1;
        bus.mem_addr     = '0;
        bus.mem_req      = 1'b0;
        bus.stall_inject = 1'b0;
        bus.prog_we      = 1'b0;
        bus.prog_addr    = '0;
        bus.prog_data    = '0;
        step();
        step();
        check("rst_valid", bus.mem_valid, 0);
        check("rst_data", bus.mem_data, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        step();
        check("post_rst_busy", bus.busy, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) prog(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) prog(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
        for (int i = 0; i < 64; i++) prog(32'(4 * i), $urandom);
        idle(2);

        // Basic line, wrapped start, stall in second beat slot, drop mid-burst.
        run_req(32'h100, -1, 1'b0, 64'h0, -1, '0, '0);
        idle(2);
        run_req(32'h108, -1, 1'b0, 64'h0, -1, '0, '0);
        idle(2);
        run_req(32'h100, -1, 1'b0, 64'h10, -1, '0, '0);
        idle(2);
        run_req(32'h100, 5, 1'b0, 64'h0, -1, '0, '0);
        idle(2);

        // Address change mid-WAIT, then immediate re-request at the new line.
        run_req(32'h100, 1, 1'b1, 64'h0, -1, '0, '0);
        run_req(32'h200, -1, 1'b0, 64'h0, -1, '0, '0);
        idle(2);

        // Reset in the first BURST cycle with a colliding write that must be dropped.
        bus.mem_addr = 32'h100;
        bus.mem_req  = 1'b1;
        step();
        step();
        step();
        rst           = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 32'h100;
        bus.prog_data = 32'hDEAD;
        step();
        rst         = 1'b0;
        bus.prog_we = 1'b0;
        bus.mem_req = 1'b0;
        last_exp    = '0;
        check("rst_burst_valid", bus.mem_valid, 0);
        check("rst_burst_data", bus.mem_data, 0);
        check("rst_burst_busy", bus.busy, 0);
        idle(2);
        run_req(32'h100, -1, 1'b0, 64'h0, -1, '0, '0);
        idle(1);

        // Write to the word being read on the same edge returns old data.
        run_req(32'h100, -1, 1'b0, 64'h0, 3, 32'h100, 32'h55);
        run_req(32'h104, -1, 1'b0, 64'h0, -1, '0, '0);
        idle(2);

        for (int r = 0; r < 25; r++) begin
            mask = '0;
            for (int k = 0; k < 16; k++) mask[k] = ($urandom_range(3) == 0);
            ab   = ($urandom_range(4) == 0) ? int'($urandom_range(10, 1)) : -1;
            addr = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(63)) << 2) | 32'($urandom_range(3));
            run_req(addr, ab, 1'b0, mask, -1, '0, '0);
            if ($urandom_range(2) == 0) prog(32'($urandom_range(63)) << 2, $urandom);
            idle(int'($urandom_range(2)));
        end

        idle(4);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
